// File: rtl/engine_ctrl.sv
// engine_ctrl: sequencing controller for a single-bin SAT solving engine.
//
// The controller starts with level-0 implication and then loops through
// decide -> imply, or conflict -> analyze -> backtrack -> imply.  It stops
// when the bin is satisfied, unsatisfiable at level 0, or when analysis asks
// for a backtrack into a different bin.  Each sub-unit is driven by a
// level-style request that is held until that unit returns its done pulse.
// Decision requests are the exception: they are a single-cycle pulse.
//
// Optional feature macro: ENGINE_CTRL_STATS_EN
//   When defined, num_decisions_o and num_conflicts_o are live 32-bit
//   counters that clear whenever a new start is accepted.
//   When undefined, both ports stay on the interface but are tied to zero,
//   and no counter registers are built.

module engine_ctrl #(
    parameter int WIDTH_LVL    = 16,
    parameter int WIDTH_BIN_ID = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    all_assigned_i,
    input  logic [WIDTH_LVL-1:0]    cur_lvl_i,
    input  logic [WIDTH_BIN_ID-1:0] cur_bin_num_i,
    input  logic [WIDTH_BIN_ID-1:0] bkt_bin_i,
    input  logic [WIDTH_LVL-1:0]    bkt_lvl_i,
    input  logic                    done_decision_i,
    input  logic                    done_imply_i,
    input  logic                    find_conflict_i,
    input  logic                    done_analyze_i,
    input  logic                    done_bkt_cur_bin_i,
    output logic                    start_decision_o,
    output logic                    apply_imply_o,
    output logic                    apply_analyze_o,
    output logic                    apply_bkt_cur_bin_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [1:0]              result_o,
    output logic [31:0]             num_decisions_o,
    output logic [31:0]             num_conflicts_o
);

    // Completion codes reported on result_o.
    localparam logic [1:0] RES_SAT           = 2'd0;
    localparam logic [1:0] RES_UNSAT         = 2'd1;
    localparam logic [1:0] RES_BKT_OTHER_BIN = 2'd2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DECIDE   = 3'd1,
        WAIT_DEC = 3'd2,
        IMPLY    = 3'd3,
        ANALYZE  = 3'd4,
        ANA_REL  = 3'd5,
        BKT      = 3'd6,
        DONE     = 3'd7
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] result;
    logic [1:0] result_next;

    // The backtrack level belongs to the backtrack unit itself.  It is part
    // of the interface so that the whole handshake bundle is visible in one
    // place, but the sequencing here does not depend on it.
    logic unused_bkt_lvl;
    assign unused_bkt_lvl = ^bkt_lvl_i;

    // State register; a synchronous active-low reset aborts any operation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the completion code on the edge that enters DONE, then hold it
    // until the next completion so software can read it at leisure.
    always_ff @(posedge clk) begin
        if (!rst) begin
            result <= RES_SAT;
        end else if ((state_next == DONE) && (state != DONE)) begin
            result <= result_next;
        end
    end

    // Next-state and request decode.  Each request is a pure function of the
    // registered state, so at most one request can be high in any cycle, and
    // handshake inputs are only looked at in the state that waits for them.
    always_comb begin
        state_next          = state;
        result_next         = result;
        start_decision_o    = 1'b0;
        apply_imply_o       = 1'b0;
        apply_analyze_o     = 1'b0;
        apply_bkt_cur_bin_o = 1'b0;
        busy_o              = 1'b0;
        done_o              = 1'b0;

        case (state)
            IDLE: begin
                // Level-0 implications are propagated before the first decision.
                if (start_i) begin
                    state_next = IMPLY;
                end
            end

            DECIDE: begin
                busy_o           = 1'b1;
                start_decision_o = 1'b1;
                state_next       = WAIT_DEC;
            end

            WAIT_DEC: begin
                busy_o = 1'b1;
                if (done_decision_i) begin
                    state_next = IMPLY;
                end
            end

            IMPLY: begin
                busy_o        = 1'b1;
                apply_imply_o = 1'b1;
                if (done_imply_i) begin
                    if (find_conflict_i) begin
                        if (cur_lvl_i == '0) begin
                            state_next  = DONE;
                            result_next = RES_UNSAT;
                        end else begin
                            state_next = ANALYZE;
                        end
                    end else if (all_assigned_i) begin
                        state_next  = DONE;
                        result_next = RES_SAT;
                    end else begin
                        state_next = DECIDE;
                    end
                end
            end

            ANALYZE: begin
                busy_o          = 1'b1;
                apply_analyze_o = 1'b1;
                if (done_analyze_i) begin
                    state_next = ANA_REL;
                end
            end

            ANA_REL: begin
                // One quiet cycle lets the analyzer's state list return to its
                // idle state before the backtrack target is compared.
                busy_o = 1'b1;
                if (bkt_bin_i != cur_bin_num_i) begin
                    state_next  = DONE;
                    result_next = RES_BKT_OTHER_BIN;
                end else begin
                    state_next = BKT;
                end
            end

            BKT: begin
                busy_o              = 1'b1;
                apply_bkt_cur_bin_o = 1'b1;
                if (done_bkt_cur_bin_i) begin
                    // Re-imply so that the learnt clause propagates.
                    state_next = IMPLY;
                end
            end

            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign result_o = result;

`ifdef ENGINE_CTRL_STATS_EN
    logic [31:0] decisions;
    logic [31:0] conflicts;

    // Statistics: one count per decision pulse and per entry to ANALYZE.
    // Both counters clear on an accepted start and wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            decisions <= '0;
            conflicts <= '0;
        end else if ((state == IDLE) && start_i) begin
            decisions <= '0;
            conflicts <= '0;
        end else begin
            if (state == DECIDE) begin
                decisions <= decisions + 32'd1;
            end
            if ((state == IMPLY) && (state_next == ANALYZE)) begin
                conflicts <= conflicts + 32'd1;
            end
        end
    end

    assign num_decisions_o = decisions;
    assign num_conflicts_o = conflicts;
`else
    assign num_decisions_o = '0;
    assign num_conflicts_o = '0;
`endif

endmodule

// File: doc/engine_ctrl.md
ENGINE_CTRL -- requirements
Module: engine_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH_LVL, default 16, the decision-level width.
REQ-002 The block SHALL have parameter WIDTH_BIN_ID, default 10, the bin-id width.
REQ-003 The block SHALL have port clk, input, 1, clock.
REQ-004 The block SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-005 The block SHALL have port start_i, input, 1, one-cycle pulse that starts solving the loaded bin.
REQ-006 The block SHALL have port all_assigned_i, input, 1, high when every bin variable has a value.
REQ-007 The block SHALL have port cur_lvl_i, input, WIDTH_LVL, current decision level.
REQ-008 The block SHALL have port cur_bin_num_i, input, WIDTH_BIN_ID, id of the bin being solved.
REQ-009 The block SHALL have port bkt_bin_i, input, WIDTH_BIN_ID, backtrack target bin.
REQ-010 The block SHALL have port bkt_lvl_i, input, WIDTH_LVL, backtrack target level.
REQ-011 The block SHALL have ports done_decision_i, done_imply_i, find_conflict_i, done_analyze_i and done_bkt_cur_bin_i, each input, 1, the handshake returns from the state list.
REQ-012 The block SHALL have port start_decision_o, output, 1, decision request pulse.
REQ-013 The block SHALL have ports apply_imply_o, apply_analyze_o and apply_bkt_cur_bin_o, each output, 1, level requests.
REQ-014 The block SHALL have port busy_o, output, 1, high from the cycle after an accepted start_i until done_o.
REQ-015 The block SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-016 The block SHALL have port result_o, output, 2, completion code: 0 SAT, 1 UNSAT, 2 BKT_OTHER_BIN; valid while done_o is high and held afterwards.
REQ-017 The block SHALL have ports num_decisions_o and num_conflicts_o, each output, 32, statistics counters.

Function
REQ-018 The FSM SHALL have the states IDLE, DECIDE, WAIT_DEC, IMPLY, ANALYZE, ANA_REL, BKT and DONE, all registered.
REQ-019 IDLE: when start_i=1, the FSM SHALL go to IMPLY, so that level-0 implications are propagated before the first decision; start_i SHALL be ignored in every other state.
REQ-020 DECIDE: the block SHALL assert start_decision_o for exactly one cycle, then go to WAIT_DEC.
REQ-021 WAIT_DEC: on done_decision_i=1 the FSM SHALL go to IMPLY; otherwise it SHALL hold with no timeout.
REQ-022 IMPLY: apply_imply_o SHALL be held high while in IMPLY and deasserted on the cycle after done_imply_i=1 is sampled.
REQ-023 On done_imply_i with find_conflict_i=1 and cur_lvl_i==0, the FSM SHALL go to DONE with result UNSAT.
REQ-024 On done_imply_i with find_conflict_i=1 and cur_lvl_i!=0, the FSM SHALL go to ANALYZE.
REQ-025 On done_imply_i with find_conflict_i=0, the FSM SHALL go to DONE with result SAT if all_assigned_i=1, else to DECIDE.
REQ-026 ANALYZE: apply_analyze_o SHALL be held high until done_analyze_i=1, then the FSM SHALL go to ANA_REL with apply_analyze_o low, so the state list can return to its idle state.
REQ-027 ANA_REL: the block SHALL wait one cycle, then compare bkt_bin_i with cur_bin_num_i.
REQ-028 ANA_REL with a mismatch: the FSM SHALL go to DONE with result BKT_OTHER_BIN.
REQ-029 ANA_REL with a match: the FSM SHALL go to BKT.
REQ-030 BKT: apply_bkt_cur_bin_o SHALL be held high until done_bkt_cur_bin_i=1, then the FSM SHALL go to IMPLY, so the learnt clause propagates.
REQ-031 DONE: the block SHALL pulse done_o for one cycle, then return to IDLE; result_o SHALL be registered when DONE is entered.
REQ-032 At most one of the four request outputs SHALL be high in any cycle.
REQ-033 A handshake input arriving in a state that does not expect it SHALL be ignored.
REQ-034 A done input and find_conflict_i sampled in the same cycle SHALL be treated as one event, as in REQ-023/REQ-024.

Reset
REQ-035 With rst=0 at a clock edge, the FSM SHALL go to IDLE.
REQ-036 With rst=0 at a clock edge, all request outputs, busy_o and done_o SHALL be 0, result_o SHALL be 0, and both counters SHALL be 0.
REQ-037 A reset during any state SHALL abort the operation, with all request outputs low on the next cycle.

Configuration
REQ-038 With ENGINE_CTRL_STATS_EN defined, num_decisions_o SHALL increment on each start_decision_o pulse.
REQ-039 With ENGINE_CTRL_STATS_EN defined, num_conflicts_o SHALL increment on each entry to ANALYZE.
REQ-040 With ENGINE_CTRL_STATS_EN defined, both counters SHALL clear when start_i is accepted, wrap at 2^32 and hold while IDLE.
REQ-041 Without ENGINE_CTRL_STATS_EN, both counter ports SHALL remain and SHALL be constant 0, with no counter registers.

Verification
REQ-042 The bench SHALL cover: start_i; done_imply_i after 3 cycles with find_conflict_i=0 and all_assigned_i=0; done_decision_i; done_imply_i with all_assigned_i=1 -> one start_decision_o pulse, done_o with result_o=0, num_decisions_o=1.
REQ-043 The bench SHALL cover: start_i; done_imply_i with find_conflict_i=1 and cur_lvl_i=0 -> no apply_analyze_o, done_o with result_o=1.
REQ-044 The bench SHALL cover: a conflict at cur_lvl_i=3, then done_analyze_i with bkt_bin_i=cur_bin_num_i=5 -> apply_analyze_o drops, apply_bkt_cur_bin_o held until done_bkt_cur_bin_i, then apply_imply_o reasserts, num_conflicts_o=1.
REQ-045 The bench SHALL cover: a conflict with bkt_bin_i=2 and cur_bin_num_i=5 -> no apply_bkt_cur_bin_o, done_o with result_o=2.
REQ-046 The bench SHALL cover: rst=0 asserted during BKT -> all outputs 0 the next cycle, and a later start_i runs normally.
REQ-047 The bench SHALL cover: start_i pulsed while busy_o=1, and a stray done_analyze_i during IMPLY -> both ignored, sequence unchanged.
